// File: rtl/convolution_coprocessor_accumulator.sv
// convolution_coprocessor_accumulator
// Sums a burst of num_terms signed partial products into a wide accumulator
// and presents one convolution sample per burst through a valid/ready
// handshake. The handshake outputs are registered decodes of the next state,
// so they have no combinational path from in_valid or out_ready.
module convolution_coprocessor_accumulator #(
  parameter int DATA_WIDTH = 6,
  parameter int ACC_WIDTH  = 12,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_terms,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [ACC_WIDTH-1:0]  out_data,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Sign-extends one adder term to the accumulator width.
  function automatic logic [ACC_WIDTH-1:0] sext_term(input logic [DATA_WIDTH-1:0] d);
    sext_term = {{(ACC_WIDTH-DATA_WIDTH){d[DATA_WIDTH-1]}}, d};
  endfunction

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [ACC_WIDTH-1:0] ACC_ZERO = {ACC_WIDTH{1'b0}};

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   n_lat_q, n_lat_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [CNT_WIDTH-1:0]   last_idx_s;
  logic                   accept_s;

  assign last_idx_s = n_lat_q - CNT_ONE;
  // in_ready_q is high exactly when the FSM is in ACCUM.
  assign accept_s   = in_valid & in_ready_q;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    n_lat_d = n_lat_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = ACC_ZERO;
          cnt_d   = CNT_ZERO;
          n_lat_d = num_terms;
          if (num_terms == CNT_ZERO) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (accept_s) begin
          acc_d = acc_q + sext_term(in_data);
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == last_idx_s) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (out_valid_q && out_ready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    in_ready_d  = (state_d == ST_ACCUM);
    out_valid_d = (state_d == ST_HOLD);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any burst in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= ACC_ZERO;
      cnt_q       <= CNT_ZERO;
      n_lat_q     <= CNT_ZERO;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      n_lat_q     <= n_lat_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = acc_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_convolution_coprocessor_accumulator.sv
// Directed bench for convolution_coprocessor_accumulator: a table of bursts
// with hand-computed sums, plus hand-written reset, chaining and
// backpressure/gap sequences. Inputs change and outputs are sampled on the
// falling edge.
module tb_convolution_coprocessor_accumulator;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  num_terms;
  logic        in_valid;
  logic [5:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [11:0] out_data;
  logic        out_ready;
  logic        busy;
  logic        done;

  int n_tests;
  int n_fail;

  convolution_coprocessor_accumulator #(
    .DATA_WIDTH(6), .ACC_WIDTH(12), .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_terms(num_terms),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       n;
    logic [15:0][5:0] t;
    logic [11:0]      exp;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Caller is at a falling edge. Runs a stall-free burst with out_ready high
  // and returns at the falling edge where done is visible, so a following
  // call asserts start in the done cycle.
  task automatic run_burst(input logic [3:0] n, input logic [15:0][5:0] t,
                           input logic [11:0] exp);
    start     = 1'b1;
    num_terms = n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    if (n == 4'd0) begin
      chk("zero_in_ready", {31'd0, in_ready}, 32'd0);
    end else begin
      for (int i = 0; i < int'(n); i++) begin
        chk("in_ready_accum", {31'd0, in_ready}, 32'd1);
        chk("no_out_valid_accum", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b1;
        in_data  = t[i];
        @(negedge clk);
      end
      in_valid = 1'b0;
      in_data  = 6'd0;
    end
    chk("out_valid_latency", {31'd0, out_valid}, 32'd1);
    chk("in_ready_hold", {31'd0, in_ready}, 32'd0);
    chk("out_data", {20'd0, out_data}, {20'd0, exp});
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("idle_after_hs", {31'd0, busy}, 32'd0);
    chk("out_valid_drop", {31'd0, out_valid}, 32'd0);
  endtask

  logic [15:0][5:0] tv;
  logic [11:0]      held;
  int               k;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0; start = 1'b0; num_terms = 4'd0; in_valid = 1'b0;
    in_data = 6'd0; out_ready = 1'b0;

    // Vector table: {num_terms, terms, expected sum}
    vecs[0].n = 4'd4;  vecs[0].t = '0;
    vecs[0].t[0] = 6'd5; vecs[0].t[1] = 6'h3D; vecs[0].t[2] = 6'd7; vecs[0].t[3] = 6'd2;
    vecs[0].exp = 12'd11;
    vecs[1].n = 4'd3;  vecs[1].t = '0;
    vecs[1].t[0] = 6'h20; vecs[1].t[1] = 6'h20; vecs[1].t[2] = 6'h20;
    vecs[1].exp = 12'hFA0;
    vecs[2].n = 4'd15; vecs[2].t = '0;
    for (int i = 0; i < 15; i++) vecs[2].t[i] = 6'd31;
    vecs[2].exp = 12'd465;
    vecs[3].n = 4'd0;  vecs[3].t = '0; vecs[3].exp = 12'd0;
    vecs[4].n = 4'd1;  vecs[4].t = '0; vecs[4].t[0] = 6'h3F; vecs[4].exp = 12'hFFF;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_out_data", {20'd0, out_data}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      run_burst(vecs[v].n, vecs[v].t, vecs[v].exp);
      @(negedge clk);
    end

    // Chained bursts, each start coinciding with the previous done pulse
    for (int b = 0; b < 8; b++) begin
      run_burst(vecs[2].n, vecs[2].t, 12'd465);
    end
    @(negedge clk);

    // Reset mid-ACCUM after 2 of 4 terms
    start = 1'b1; num_terms = 4'd4;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_data = 6'd9;
    @(negedge clk);
    in_data = 6'd10;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_out_data", {20'd0, out_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tv = '0; tv[0] = 6'd1; tv[1] = 6'd1;
    run_burst(4'd2, tv, 12'd2);
    @(negedge clk);

    // Gaps in in_valid, backpressure, and start pulses during HOLD
    start = 1'b1; num_terms = 4'd3; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    tv = '0; tv[0] = 6'd4; tv[2] = 6'h3A; tv[4] = 6'd9;
    for (int c = 0; c < 5; c++) begin
      chk("gap_in_ready", {31'd0, in_ready}, 32'd1);
      in_valid = (c % 2 == 0);
      in_data  = (c % 2 == 0) ? tv[c] : 6'd31;
      @(negedge clk);
    end
    in_valid = 1'b1; in_data = 6'd31;
    k = 0;
    while (!out_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("gap_out_valid_seen", {31'd0, out_valid}, 32'd1);
    chk("gap_out_valid_wait", k, 32'd0);
    held = out_data;
    chk("gap_sum", {20'd0, out_data}, 32'd7);
    for (int c = 0; c < 5; c++) begin
      start = (c % 2 == 0);
      num_terms = 4'd2;
      @(negedge clk);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_stable", {20'd0, out_data}, {20'd0, held});
      chk("bp_no_done", {31'd0, done}, 32'd0);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    start = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_done", {31'd0, done}, 32'd1);
    chk("bp_idle", {31'd0, busy}, 32'd0);
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_done_one_cycle", {31'd0, done}, 32'd0);
    chk("bp_stays_idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/convolution_coprocessor_accumulator.md
# convolution_coprocessor_accumulator

Sequential accumulation stage directly downstream of the coprocessor's 2's-complement real adder. It sums a burst of `num_terms` signed partial products (one per tap) into a wider register, producing one convolution output sample per burst. It has valid/ready handshakes on both sides and sits between the tap multiplier/adder datapath and the result writeback.

## Interface
- `DATA_WIDTH`, 6: width of each signed input term, matching the adder output width.
- `ACC_WIDTH`, 12: width of the signed accumulator and result. Must be ≥ `DATA_WIDTH` + `CNT_WIDTH`.
- `CNT_WIDTH`, 4: width of the term counter and `num_terms`.

- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: one-cycle request to begin a burst. Sampled only in IDLE.
- `num_terms`, input, `CNT_WIDTH`: terms per burst. Latched on an accepted `start`.
- `in_valid`, input, 1: upstream term valid.
- `in_data`, input, `DATA_WIDTH`: signed 2's-complement term.
- `in_ready`, output, 1: the block accepts a term this cycle.
- `out_valid`, output, 1: `out_data` holds a finished sample.
- `out_data`, output, `ACC_WIDTH`: signed accumulated sample.
- `out_ready`, input, 1: downstream accepts `out_data`.
- `busy`, output, 1: FSM is not in IDLE.
- `done`, output, 1: one-cycle pulse in the cycle after the output handshake.

## Operation
- FSM states:
  - IDLE: `in_ready`=0, `out_valid`=0.
  - ACCUM: `in_ready`=1.
  - HOLD: `out_valid`=1.
- IDLE → ACCUM on `start`:
  - `acc` is cleared to 0.
  - `cnt` is cleared to 0.
  - `num_terms` is latched into `n_lat`.
- IDLE → HOLD on `start` with `num_terms`=0: `acc` is cleared and an output of 0 is presented; no input is accepted.
- ACCUM: a term is accepted when `in_valid` and `in_ready` are both 1. On acceptance:
  - `acc` ← `acc` + sign-extended `in_data`.
  - `cnt` ← `cnt`+1.
- ACCUM → HOLD on the accepted term where `cnt` = `n_lat`−1. That term is included in `acc`.
- HOLD: `out_data` = `acc`, held stable until `out_valid` and `out_ready` are both 1. On the handshake:
  - FSM goes to IDLE.
  - `done` pulses 1 on the next cycle.
- `start` is ignored outside IDLE. `in_valid` is ignored outside ACCUM, and `in_data` is not consumed.
- Arithmetic: `in_data` is sign-extended to `ACC_WIDTH`. Addition wraps modulo 2^`ACC_WIDTH`; no saturation and no overflow flag.
- `out_data` reflects `acc` in all states but is meaningful only while `out_valid`=1.

## Timing
- Reset (async assert, sync release) values:
  - FSM = IDLE.
  - `acc`, `cnt`, `n_lat` = 0.
  - `in_ready`, `out_valid`, `busy`, `done` = 0.
  - `out_data` = 0.
- `in_ready`, `out_valid` and `busy` are registered-state decodes with no combinational path from `in_valid` or `out_ready`.
- `start` in cycle t gives `in_ready`=1 in cycle t+1.
- Latency: last term accepted in cycle t gives `out_valid`=1 in cycle t+1.
- `out_ready` already high gives a handshake in cycle t+1, `done`=1 and IDLE in t+2.
- Peak throughput: 1 term per cycle. A burst of N terms with no stalls occupies N+2 cycles from `start` to `done`.
- A gap in `in_valid` stalls ACCUM with no state change.
- `rst_n` low mid-burst or in HOLD immediately aborts: outputs go to reset values and the partial sum is discarded.
- `start` in the same cycle as the `done` pulse is accepted, because the FSM is already in IDLE.

## Test plan
- Reset: assert `rst_n`=0 mid-ACCUM after 2 of 4 terms, then release and burst {1,1} → `out_data`=2, with all outputs 0 during reset.
- Basic burst: `num_terms`=4, terms {5, −3, 7, 2}, `out_ready`=1 → `out_data`=11, `out_valid` one cycle after the 4th term, `done` one cycle after that.
- Sign extension: `num_terms`=3, terms {−32, −32, −32} with `DATA_WIDTH`=6 → `out_data`=−96 (12'hFA0).
- Wrap-around: `num_terms`=15, every term 31 → 465 fits; then 8 bursts chained in a TB loop verify no carry-over between bursts (each = 465).
- Backpressure and gaps: `num_terms`=3, `in_valid` toggling 1,0,1,0,1, `out_ready` low for 5 cycles → `out_data`=sum, held stable, and `start` pulses during HOLD are ignored.
- Zero-length: `num_terms`=0 → HOLD the cycle after `start` with `out_data`=0, `in_ready` never asserts.
